interval_timer_ctrl: RTL and testbench

INTERVAL_TIMER_CTRL -- requirements
Module: interval_timer_ctrl

---
 rtl/interval_timer_ctrl.sv | 146 ++++++++++++++
 tb/tb_interval_timer_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/interval_timer_ctrl.sv
// ---------------------------------------------------------------------------
// interval_timer_ctrl
//
// Purpose:
//   Programmable interval timer with a valid/ready configuration port.
//   A latched terminal count (period) and mode (periodic / one-shot) control
//   a counter that runs from 0 up to period inclusive. One period therefore
//   lasts period+1 cycles. At the end of each period the block pulses
//   expire, sets the sticky irq flag, and flags overrun if the previous irq
//   has not yet been acknowledged.
//
// Ports:
//   clk          - single clock, all state changes on its rising edge
//   rst          - synchronous, active-high reset
//   cfg_valid    - configuration offer valid
//   cfg_ready    - configuration can be accepted (IDLE and not in reset)
//   cfg_period   - terminal count, WIDTH bits
//   cfg_periodic - 1 = periodic, 0 = one-shot
//   start        - run request (ignored while running)
//   stop         - abort request (wins over start, suppresses expire)
//   busy         - high while the timer is running
//   count        - current counter value
//   expire       - registered one-cycle pulse per completed period
//   irq          - sticky expiry flag, cleared by irq_ack
//   irq_ack      - clears irq and overrun
//   overrun      - sticky flag: an expiry happened while irq was pending
// ---------------------------------------------------------------------------
module interval_timer_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_period,
  input  logic             cfg_periodic,
  input  logic             start,
  input  logic             stop,
  output logic             busy,
  output logic [WIDTH-1:0] count,
  output logic             expire,
  output logic             irq,
  input  logic             irq_ack,
  output logic             overrun
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] period_q;
  logic             periodic_q;
  logic             term;

  // The configuration port only opens while idle and out of reset, so a
  // running period can never be disturbed by a new offer.
  assign cfg_ready = (state == IDLE) && !rst;
  assign busy      = (state == RUN);

  // End of a period this cycle. A stop in the same cycle cancels it, so an
  // aborted run never produces an expire.
  assign term = (state == RUN) && !stop && (count == period_q);

  // Timer FSM with all registered outputs. The counter runs 0..period_q and
  // returns to 0 on the terminal cycle rather than overflowing, which makes
  // period_q = all-ones behave exactly like any other period. irq/overrun
  // give priority to a new expiry over an acknowledge: an expiry that
  // coincides with irq_ack leaves irq set and overrun untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      count      <= '0;
      expire     <= 1'b0;
      irq        <= 1'b0;
      overrun    <= 1'b0;
      period_q   <= '1;
      periodic_q <= 1'b0;
    end else begin
      expire <= term;

      case (state)
        IDLE: begin
          count <= '0;
          if (cfg_valid && cfg_ready) begin
            period_q   <= cfg_period;
            periodic_q <= cfg_periodic;
          end
          if (start && !stop) begin
            state <= RUN;
          end
        end

        RUN: begin
          if (stop) begin
            state <= IDLE;
            count <= '0;
          end else if (term) begin
            count <= '0;
            if (!periodic_q) begin
              state <= IDLE;
            end
          end else begin
            count <= count + 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          count <= '0;
        end
      endcase

      if (term) begin
        irq <= 1'b1;
        if (irq && !irq_ack) begin
          overrun <= 1'b1;
        end
      end else if (irq_ack) begin
        irq     <= 1'b0;
        overrun <= 1'b0;
      end
    end
  end

  // The counter never runs past the latched terminal count.
  count_in_range: assert property (
    @(posedge clk) disable iff (rst) count <= period_q
  );

  // While running (and not aborted) the counter either steps by one or
  // returns to 0, and it returns to 0 exactly when expire fires.
  count_steps: assert property (
    @(posedge clk) disable iff (rst)
      (busy && !stop) |=> (expire ? (count == '0)
                                  : (count == WIDTH'($past(count) + 1'b1)))
  );

  // Back-to-back expire pulses are only possible with a zero period.
  expire_spacing: assert property (
    @(posedge clk) disable iff (rst)
      expire |=> (!expire || (period_q == '0))
  );

endmodule

// File: tb/tb_interval_timer_ctrl.sv
// ---------------------------------------------------------------------------
// tb_interval_timer_ctrl
//
// Purpose:
//   Self-checking bench for interval_timer_ctrl (WIDTH = 4). A reference
//   model describes the timer in terms of "cycles elapsed since start":
//   count is elapsed mod (period+1) and an expiry happens whenever elapsed
//   is a positive multiple of period+1. A compare process checks every DUT
//   output against that model on each falling edge, directed scenarios pin
//   hand-computed values, and a randomized phase exercises the rest.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_interval_timer_ctrl;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         cfg_valid;
  logic         cfg_ready;
  logic [W-1:0] cfg_period;
  logic         cfg_periodic;
  logic         start;
  logic         stop;
  logic         busy;
  logic [W-1:0] count;
  logic         expire;
  logic         irq;
  logic         irq_ack;
  logic         overrun;

  int errors = 0;
  int checks = 0;

  interval_timer_ctrl #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_period   (cfg_period),
    .cfg_periodic (cfg_periodic),
    .start        (start),
    .stop         (stop),
    .busy         (busy),
    .count        (count),
    .expire       (expire),
    .irq          (irq),
    .irq_ack      (irq_ack),
    .overrun      (overrun)
  );

  // 10-unit clock period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state, expressed as elapsed cycles since the run began
  typedef struct {
    bit valid;
    bit running;
    int elapsed;
    int period;
    bit periodic;
    bit exp;
    bit irq;
    bit ovr;
  } model_t;

  model_t m;

  initial begin
    m = '{valid: 1'b0, running: 1'b0, elapsed: 0, period: (1 << W) - 1,
          periodic: 1'b0, exp: 1'b0, irq: 1'b0, ovr: 1'b0};
  end

  // One clock edge of the timer's behaviour, from the rules directly
  function automatic model_t modelStep(model_t cur, bit r, bit v, int p,
                                       bit pm, bit s, bit sp, bit ack);
    model_t nxt;
    nxt = cur;
    if (r) begin
      nxt.valid    = 1'b1;
      nxt.running  = 1'b0;
      nxt.elapsed  = 0;
      nxt.period   = (1 << W) - 1;
      nxt.periodic = 1'b0;
      nxt.exp      = 1'b0;
      nxt.irq      = 1'b0;
      nxt.ovr      = 1'b0;
      return nxt;
    end
    nxt.exp = 1'b0;
    if (!cur.running) begin
      if (v) begin
        nxt.period   = p;
        nxt.periodic = pm;
      end
      if (s && !sp) begin
        nxt.running = 1'b1;
        nxt.elapsed = 0;
      end
    end else if (sp) begin
      nxt.running = 1'b0;
      nxt.elapsed = 0;
    end else begin
      nxt.elapsed = cur.elapsed + 1;
      if (nxt.elapsed % (cur.period + 1) == 0) begin
        nxt.exp = 1'b1;
        if (!cur.periodic) begin
          nxt.running = 1'b0;
          nxt.elapsed = 0;
        end
      end
    end
    if (nxt.exp) begin
      if (cur.irq && !ack) nxt.ovr = 1'b1;
      nxt.irq = 1'b1;
    end else if (ack) begin
      nxt.irq = 1'b0;
      nxt.ovr = 1'b0;
    end
    return nxt;
  endfunction

  // Advance the model on every rising edge using the inputs held that cycle
  always @(posedge clk) begin
    m <= modelStep(m, rst, cfg_valid, int'(cfg_period), cfg_periodic,
                   start, stop, irq_ack);
  end

  task automatic checkOutput(input string name, input int actual,
                             input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at time %0t",
               name, actual, expected, $time);
    end
  endtask

  // Compare every DUT output against the model on each falling edge
  always @(negedge clk) begin
    if (m.valid) begin
      checkOutput("model count", int'(count),
                  m.running ? (m.elapsed % (m.period + 1)) : 0);
      checkOutput("model busy", int'(busy), int'(m.running));
      checkOutput("model expire", int'(expire), int'(m.exp));
      checkOutput("model irq", int'(irq), int'(m.irq));
      checkOutput("model overrun", int'(overrun), int'(m.ovr));
      checkOutput("model cfg_ready", int'(cfg_ready),
                  int'(!m.running && !rst));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit v, input int p, input bit pm,
                               input bit s, input bit sp, input bit ack);
    cfg_valid    = v;
    cfg_period   = W'(p);
    cfg_periodic = pm;
    start        = s;
    stop         = sp;
    irq_ack      = ack;
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0);
    tick();
    tick();

    // Reset state
    checkOutput("reset count", int'(count), 0);
    checkOutput("reset busy", int'(busy), 0);
    checkOutput("reset expire", int'(expire), 0);
    checkOutput("reset irq", int'(irq), 0);
    checkOutput("reset overrun", int'(overrun), 0);
    checkOutput("reset cfg_ready", int'(cfg_ready), 0);

    // One-shot, period 3, configured in the first cycle out of reset
    $display("[TB] one-shot period 3");
    rst = 1'b0;
    applyStimulus(1, 3, 0, 0, 0, 0);
    #1;
    checkOutput("first cycle cfg_ready", int'(cfg_ready), 1);
    tick();
    applyStimulus(0, 0, 0, 1, 0, 0);
    tick();
    checkOutput("A start busy", int'(busy), 1);
    checkOutput("A start count", int'(count), 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      checkOutput("A count", int'(count), k);
      checkOutput("A expire low", int'(expire), 0);
    end
    tick();
    checkOutput("A expire", int'(expire), 1);
    checkOutput("A busy done", int'(busy), 0);
    checkOutput("A irq", int'(irq), 1);
    checkOutput("A count done", int'(count), 0);
    tick();
    checkOutput("A expire pulse", int'(expire), 0);
    applyStimulus(0, 0, 0, 0, 0, 1);
    tick();
    checkOutput("A irq ack", int'(irq), 0);

    // Periodic, period 2, no acknowledge until after a stop
    $display("[TB] periodic period 2");
    applyStimulus(1, 2, 1, 1, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 9; k++) begin
      tick();
      checkOutput("B expire", int'(expire), (k % 3 == 0) ? 1 : 0);
      checkOutput("B irq", int'(irq), (k >= 3) ? 1 : 0);
      checkOutput("B overrun", int'(overrun), (k >= 6) ? 1 : 0);
    end
    applyStimulus(0, 0, 0, 0, 1, 0);
    tick();
    checkOutput("B stop busy", int'(busy), 0);
    checkOutput("B overrun kept by stop", int'(overrun), 1);
    applyStimulus(0, 0, 0, 0, 0, 1);
    tick();
    checkOutput("B ack irq", int'(irq), 0);
    checkOutput("B ack overrun", int'(overrun), 0);

    // Stop on the terminal cycle suppresses the expiry
    $display("[TB] stop at terminal count");
    applyStimulus(1, 3, 0, 1, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0);
    tick();
    tick();
    tick();
    checkOutput("C count at terminal", int'(count), 3);
    applyStimulus(0, 0, 0, 0, 1, 0);
    tick();
    checkOutput("C stop busy", int'(busy), 0);
    checkOutput("C stop count", int'(count), 0);
    checkOutput("C stop expire", int'(expire), 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    tick();
    checkOutput("C expire after stop", int'(expire), 0);
    checkOutput("C irq after stop", int'(irq), 0);

    // Handshake and start together use the new period
    $display("[TB] config with start");
    applyStimulus(1, 1, 0, 1, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0);
    tick();
    checkOutput("D expire early", int'(expire), 0);
    tick();
    checkOutput("D expire", int'(expire), 1);
    checkOutput("D busy", int'(busy), 0);

    // Reset mid-run
    $display("[TB] reset mid-run");
    applyStimulus(1, 15, 0, 1, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0);
    tick();
    tick();
    checkOutput("E count before reset", int'(count), 2);
    rst = 1'b1;
    tick();
    checkOutput("E reset count", int'(count), 0);
    checkOutput("E reset busy", int'(busy), 0);
    checkOutput("E reset irq", int'(irq), 0);
    checkOutput("E cfg_ready in reset", int'(cfg_ready), 0);
    rst = 1'b0;
    #1;
    checkOutput("E cfg_ready after reset", int'(cfg_ready), 1);

    // New config offered while running is refused
    $display("[TB] config during run");
    applyStimulus(1, 3, 1, 1, 0, 0);
    tick();
    for (int k = 1; k <= 12; k++) begin
      applyStimulus(1, 5, 0, 0, 0, 1);
      #1;
      checkOutput("F cfg_ready in run", int'(cfg_ready), 0);
      tick();
      checkOutput("F expire", int'(expire), (k % 4 == 0) ? 1 : 0);
    end
    applyStimulus(0, 0, 0, 0, 1, 1);
    tick();
    checkOutput("F stop busy", int'(busy), 0);

    // Zero period expires every cycle
    $display("[TB] periodic period 0");
    applyStimulus(1, 0, 1, 1, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      checkOutput("G expire", int'(expire), 1);
      checkOutput("G count", int'(count), 0);
      checkOutput("G overrun", int'(overrun), (k >= 2) ? 1 : 0);
    end
    applyStimulus(0, 0, 0, 0, 1, 1);
    tick();

    // Full-range period wraps from all-ones to zero
    $display("[TB] periodic period max");
    applyStimulus(1, 15, 1, 1, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 16; k++) begin
      tick();
      checkOutput("H count", int'(count), k % 16);
      checkOutput("H expire", int'(expire), (k == 16) ? 1 : 0);
    end
    applyStimulus(0, 0, 0, 0, 1, 1);
    tick();

    // Randomized traffic checked by the model compare process
    $display("[TB] random phase");
    for (int n = 0; n < 3000; n++) begin
      int psel;
      int pval;
      psel = int'($urandom_range(0, 3));
      pval = (psel == 0) ? 0 : (psel == 1) ? 15 : int'($urandom_range(0, 15));
      rst = ($urandom_range(0, 199) == 0);
      applyStimulus($urandom_range(0, 4) == 0, pval, 1'($urandom_range(0, 1)),
                    $urandom_range(0, 5) == 0, $urandom_range(0, 24) == 0,
                    $urandom_range(0, 4) == 0);
      tick();
    end
    rst = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0);
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
